// File: rtl/ram_pkg.sv
// Shared widths and word/address types for the 4096x64 RAM.
package ram_pkg;
    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 12;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] ram_data_t;
    typedef logic [ADDR_WIDTH-1:0] ram_addr_t;
endpackage

// File: rtl/ram_4096x64_array.sv
// Plain storage: one write port, one registered read port, no reset, so it maps onto block RAM.
module ram_4096x64_array
    import ram_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_data_q;

    // Both ports in one process: the read samples the pre-write word (read-first).
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q    <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/ram_4096x64.sv
// Simple dual-port 4096x64 RAM with per-word valid bits; unwritten words read as zero.
module ram_4096x64 #(
    parameter int DATA_WIDTH = ram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = ram_pkg::ADDR_WIDTH,
    parameter int DEPTH      = ram_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] data_out
);
    logic                  wr_en, rd_en;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] rd_data;

    assign wr_en = write & ~reset;
    assign rd_en = read  & ~reset;

    ram_4096x64_array #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_address),
        .wr_data (data_in),
        .rd_en   (rd_en),
        .rd_addr (rd_address),
        .rd_data (rd_data)
    );

    // out_vld uses the pre-write valid bit so a same-address collision stays read-first.
    always_comb begin
        valid_d   = valid_q;
        out_vld_d = out_vld_q;
        if (read)  out_vld_d           = valid_q[rd_address];
        if (write) valid_d[wr_address] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            out_vld_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Array output only moves on a read, so masking with the held flag also holds data_out.
    assign data_out = out_vld_q ? rd_data : '0;
endmodule

// File: tb/tb_ram_4096x64.sv
// Randomized + directed scoreboard bench for ram_4096x64 against an array-based reference.
module tb_ram_4096x64;
    import ram_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    ram_data_t data_in;
    ram_addr_t wr_address, rd_address;
    logic      write, read;
    ram_data_t data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    ram_data_t   exp_q[$];
    ram_data_t   ref_mem [DEPTH];
    bit [DEPTH-1:0] ref_vld;
    ram_data_t   exp_out;
    bit          started = 0;

    ram_4096x64 dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .wr_address (wr_address),
        .write      (write),
        .rd_address (rd_address),
        .read       (read),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // Reference model: samples the bus at each rising edge, pushes the data_out due after it.
    initial begin
        ref_vld = '0;
        exp_out = '0;
        forever begin
            @(posedge clk);
            cycle++;
            if (reset === 1'b1) begin
                started = 1;
                ref_vld = '0;
                exp_out = '0;
                exp_q.push_back(exp_out);
            end else if (started) begin
                n_checks++;
                if ($isunknown(read) || $isunknown(write)) begin
                    n_fail++;
                    $display("FAIL protocol_x cycle %0d: read=%b write=%b, required known", cycle, read, write);
                end
                if (read === 1'b1)
                    exp_out = ref_vld[rd_address] ? ref_mem[rd_address] : '0;
                if (write === 1'b1) begin
                    ref_mem[wr_address] = data_in;
                    ref_vld[wr_address] = 1'b1;
                end
                exp_q.push_back(exp_out);
            end
        end
    end

    // Monitor: data_out is registered, so compare on the falling edge after each sampled edge.
    initial begin
        ram_data_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (data_out !== e) begin
                    n_fail++;
                    $display("FAIL data_out cycle %0d: got %h, expected %h", cycle, data_out, e);
                end
            end
        end
    end

    task automatic cyc(input logic rst, input logic rd, input ram_addr_t ra,
                       input logic wr, input ram_addr_t wa, input ram_data_t d);
        reset      = rst;
        read       = rd;
        rd_address = ra;
        write      = wr;
        wr_address = wa;
        data_in    = d;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0;
        rd_address = '0; wr_address = '0; data_in = '0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 12'h000, 0, 0, 0);
        cyc(0, 1, 12'hFFF, 0, 0, 0);

        cyc(0, 0, 0, 1, 12'h0A5, 64'hDEAD_BEEF_0123_4567);
        cyc(0, 1, 12'h0A5, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        cyc(0, 0, 0, 1, 12'h010, 64'h1111);
        cyc(0, 1, 12'h010, 1, 12'h010, 64'h2222);
        cyc(0, 1, 12'h010, 0, 0, 0);

        cyc(0, 0, 0, 1, 12'h200, 64'h55AA);
        cyc(0, 1, 12'h200, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0);

        for (int a = 0; a < DEPTH; a++) cyc(0, 0, 0, 1, ram_addr_t'(a), ram_data_t'(a + 1));
        for (int a = 0; a < DEPTH; a++) cyc(0, 1, ram_addr_t'(a), 0, 0, 0);

        cyc(0, 0, 0, 1, 12'h123, 64'hFFFF);
        cyc(1, 1, 12'h123, 0, 0, 0);
        cyc(0, 1, 12'h123, 0, 0, 0);
        cyc(0, 1, 12'h0A5, 0, 0, 0);

        // Narrow address window so collisions and rewrites are frequent.
        for (int i = 0; i < 2000; i++) begin
            ram_addr_t base;
            base = ram_addr_t'($urandom_range(0, 3)) << 10;
            cyc(($urandom_range(0, 63) == 0),
                $urandom_range(0, 1) == 1, base | ram_addr_t'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1, base | ram_addr_t'($urandom_range(0, 15)),
                {$urandom, $urandom});
        end

        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (exp_q.size() > 1 || !started) begin
            n_fail++;
            $display("FAIL drain: %0d expectations pending, started=%0d, required <=1 and 1", exp_q.size(), started);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end
endmodule
